parity_frame_checker: RTL

Receive-side parity checker paired with the three-input parity generator. It accepts a serial, bit-strobed frame: start bit, DATA_W data bits (LSB first), one parity bit and one stop bit. It reassembles the data word, checks parity and framing, and reports the result with a one-cycle strobe. It sits between the serial link front end and the word-level consumer.

---
 rtl/parity_pkg.sv | 18 +
 rtl/parity_frame_shift.sv | 44 ++++
 rtl/parity_frame_checker.sv | 133 +++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared state type, parity helper and counter width for the parity frame checker
package parity_pkg;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Parity bit a generator must send for a data word (up to 16 bits, zero-extended).
  function automatic logic par_of(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_shift.sv
// rtl/parity_frame_shift.sv - LSB-first data shift register with bit index and done flag
module parity_frame_shift #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_shift,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_data,
  output logic              o_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic              w_last;

  // Index points at the slot the next shifted bit lands in.
  assign w_last = (r_idx == IDX_W'(DATA_W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_data <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_idx  <= '0;
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data[r_idx] <= i_bit;
      r_idx         <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign o_data = r_data;
  assign o_done = w_last;

endmodule

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - serial frame receiver with parity/stop checking
// Optional saturating error counter on o_err_cnt when PARITY_ERR_CNT_EN is defined.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter bit ODD_PAR = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bit_in,
  input  logic              i_bit_vld,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_vld,
  output logic              o_par_err,
  output logic              o_frame_err,
  output logic              o_busy
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] o_err_cnt
`endif
);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_clear;
  logic              w_shift;
  logic              w_take_par;
  logic              w_deliver;
  logic              w_done;
  logic [DATA_W-1:0] w_shift_data;

  logic              r_par;
  logic              r_par_calc;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_vld;
  logic              r_par_err;
  logic              r_frame_err;

  parity_frame_shift #(
    .DATA_W(DATA_W)
  ) u_shift (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_clear),
    .i_load     (1'b0),
    .i_load_data('0),
    .i_shift    (w_shift),
    .i_bit      (i_bit_in),
    .o_data     (w_shift_data),
    .o_done     (w_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_take_par   = 1'b0;
    w_deliver    = 1'b0;
    if (i_bit_vld) begin
      case (r_state)
        IDLE: begin
          if (!i_bit_in) begin
            w_next_state = DATA;
            w_clear      = 1'b1;
          end
        end
        DATA: begin
          w_shift = 1'b1;
          if (w_done) w_next_state = PARITY;
        end
        PARITY: begin
          w_take_par   = 1'b1;
          w_next_state = STOP;
        end
        STOP: begin
          w_deliver    = 1'b1;
          w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Error flags are gated by the deliver strobe so they read 0 outside the pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par       <= 1'b0;
      r_par_calc  <= 1'b0;
      r_data_out  <= '0;
      r_data_vld  <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_data_vld  <= w_deliver;
      r_par_err   <= w_deliver & r_par_calc;
      r_frame_err <= w_deliver & ~i_bit_in;
      if (w_clear)      r_par <= 1'b0;
      else if (w_shift) r_par <= r_par ^ i_bit_in;
      if (w_take_par)   r_par_calc <= r_par ^ i_bit_in ^ ODD_PAR;
      if (w_deliver)    r_data_out <= w_shift_data;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_frame_bad;

  assign w_frame_bad = r_par_calc | ~i_bit_in;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (w_deliver && w_frame_bad && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

  assign o_data_out  = r_data_out;
  assign o_data_vld  = r_data_vld;
  assign o_par_err   = r_par_err;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != IDLE);

endmodule
